// File: rtl/uart_pkg.sv
// Shared state encoding and default timing constants for the FIFO-fed UART transmitter.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

  // Transmitter frame phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_W_DEF    = 8;
  localparam int UART_CLK_DIV_DEF   = 16;
  localparam int UART_STOP_BITS_DEF = 1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int uart_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLK_DIV cycles per serial bit, restarting from 0 on every bit.
// Latency: bit_end is high in the cycle before the final cycle of each bit period.
// Backpressure: none; restart holds the count at 0 (used while the line is idle).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic bit_end
);

  localparam int            CW       = uart_cnt_w(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  // bit_end fires one cycle early so the transmitter can register its
  // end-of-bit decisions (frame_done, next-bit strobe) without a combinational path.
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_DIV - 2);

  logic [CW-1:0] r_cnt;

  // Free-running bit counter, wrapping at CLK_DIV-1 and held at 0 while restart is high.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_end = ~restart & (r_cnt == CNT_PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a show-ahead sync FIFO: start bit, DATA_W bits LSB first, STOP_BITS stop bits.
// Latency: tx goes low on the edge that pops the word; a frame lasts (1+DATA_W+STOP_BITS)*CLK_DIV cycles.
// Backpressure: pops only when en=1, FIFO non-empty and the line is idle or in its final stop cycle.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W_DEF,
  parameter int CLK_DIV   = UART_CLK_DIV_DEF,   // 2..65535
  parameter int STOP_BITS = UART_STOP_BITS_DEF  // 1 or 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int            BW        = uart_cnt_w(DATA_W);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  uart_state_t       r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_bit;
  logic              r_stop;
  logic              r_tx;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_bit_last;

  logic              w_restart;
  logic              w_bit_end;
  logic              w_slot;
  logic              w_pop;

  // The counter only runs while a frame is on the line.
  assign w_restart = (r_state == IDLE);

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .rstn    (rstn),
    .restart (w_restart),
    .bit_end (w_bit_end)
  );

  // A new word may be taken when idle, or in the final stop cycle so frames stream back-to-back.
  // r_frame_done is exactly that final stop cycle; reset blocks the pop outright.
  assign w_slot = (r_state == IDLE) | r_frame_done;
  assign w_pop  = en & ~fifo_empty & ~rstn & w_slot;

  // Frame sequencer: state, shift register, bit/stop indices and all registered line outputs.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit        <= '0;
      r_stop       <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_bit_last   <= 1'b0;
    end else begin
      // r_bit_last marks the final cycle of the current bit; frame_done is that cycle of the last stop bit.
      r_bit_last   <= w_bit_end;
      r_frame_done <= (r_state == STOP) && (r_stop == STOP_LAST) && w_bit_end;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift <= fifo_rdata;
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (r_bit_last) begin
            r_state <= DATA;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        DATA: begin
          if (r_bit_last) begin
            if (r_bit == BIT_LAST) begin
              r_state <= STOP;
              r_stop  <= 1'b0;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        end
        STOP: begin
          if (r_bit_last) begin
            if (r_stop == STOP_LAST) begin
              if (w_pop) begin
                r_shift <= fifo_rdata;
                r_state <= START;
                r_tx    <= 1'b0;
                r_busy  <= 1'b1;
              end else begin
                r_state <= IDLE;
                r_tx    <= 1'b1;
                r_busy  <= 1'b0;
              end
            end else begin
              r_stop <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_pop   = w_pop;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the FIFO word width and the number of serial data bits per frame.
REQ-002 The block SHALL have parameter CLK_DIV, default 16, meaning clk cycles per serial bit; legal range is 2..65535.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values are 1 and 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port en, input, 1 bit: when 1, the block is permitted to start new frames.
REQ-007 The block SHALL have port fifo_empty, input, 1 bit: the empty flag of the upstream sync FIFO.
REQ-008 The block SHALL have port fifo_rdata, input, DATA_W bits: the upstream FIFO head word, valid whenever fifo_empty=0 (show-ahead).
REQ-009 The block SHALL have port fifo_pop, output, 1 bit: the pop strobe to the upstream FIFO.
REQ-010 The block SHALL have port tx, output, 1 bit: the serial line, idle high.
REQ-011 The block SHALL have port busy, output, 1 bit: 1 while a frame is in progress.
REQ-012 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse when a frame's final stop bit ends.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-014 fifo_pop SHALL be combinational and equal to en & ~fifo_empty & ~rstn & (state==IDLE | last cycle of STOP); it SHALL never be high for two consecutive cycles within one frame.
REQ-015 The rising edge that samples fifo_pop=1 SHALL load fifo_rdata into the shift register, enter START and drive tx=0 from that edge on.
REQ-016 START, each DATA bit and each stop bit SHALL last exactly CLK_DIV cycles, counted by the baud counter, which restarts at 0 on every bit.
REQ-017 Data bits SHALL be sent LSB first; the bit index counter SHALL run 0..DATA_W-1, after which the FSM enters STOP with tx=1.
REQ-018 A frame SHALL occupy exactly (1+DATA_W+STOP_BITS)*CLK_DIV cycles.
REQ-019 If a pop occurs in the last STOP cycle, the next START SHALL follow with no idle cycle (back-to-back streaming).
REQ-020 Otherwise the FSM SHALL return to IDLE with tx=1.
REQ-021 frame_done SHALL be 1 exactly in the last STOP cycle of every frame, including back-to-back frames.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 Deasserting en mid-frame SHALL let the current frame complete and SHALL prevent further pops.
REQ-024 fifo_empty rising mid-frame SHALL have no effect on the current frame.
REQ-025 tx, busy and frame_done SHALL be registered outputs.

Reset
REQ-026 While rstn=1, asynchronously: state=IDLE, tx=1, busy=0, frame_done=0, fifo_pop=0, and all counters and the shift register SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, driving tx=1 with no stop-bit completion, and SHALL not pop the FIFO.
REQ-028 The first pop after reset release SHALL be possible on the first clk edge at which rstn=0.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum typedef (IDLE, START, DATA, STOP) and the default constants for CLK_DIV and STOP_BITS.
REQ-030 The baud counter SHALL be a sub-module, uart_baud_gen (clk, rstn, restart, bit_end), parameterised by CLK_DIV.
REQ-031 The top SHALL instantiate exactly one uart_baud_gen and contain no other sub-modules.

Verification
REQ-032 Test: CLK_DIV=4, FIFO preloaded with 0x10 -> exactly one pop; tx reads 0, then 0,0,0,0,1,0,0,0, then 1, each bit 4 cycles; frame is 40 cycles; frame_done pulses once.
REQ-033 Test: FIFO holds 0x10,0x11,0x12,0x13 with en=1 -> 4 pops spaced exactly 40 cycles apart; tx never idles between frames; 4 frame_done pulses; fifo_empty=1 after the 4th pop.
REQ-034 Test: en=0 with a non-empty FIFO -> no pop, tx=1, busy=0; setting en=1 -> pop in that same cycle.
REQ-035 Test: en dropped during the DATA bits of 0x13 -> that frame completes; no further pop while words remain.
REQ-036 Test: rstn pulsed during bit 3 of 0xA5 -> tx=1 and busy=0 asynchronously; after release the next FIFO word is sent as a full frame.
REQ-037 Test: STOP_BITS=2, CLK_DIV=2, byte 0xFF -> frame is 22 cycles with the stop level held 4 cycles.
